multdiv_unit: RTL and testbench



---
 rtl/multdiv_unit.sv | 181 ++++++++++++++++++
 tb/tb_multdiv_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/multdiv_unit.sv
// Iterative signed 32-bit multiply/divide unit: shift-add multiply, non-restoring divide.
// Define MULTDIV_RADIX4_EN to build the multiplier as radix-4 Booth (16 iterations).
`timescale 1ns/1ps
module multdiv_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY
);

   typedef enum logic [1:0] {StIdle, StMulRun, StDivRun, StDone} state_e;

`ifdef MULTDIV_RADIX4_EN
   localparam logic [4:0] MulLast = 5'd15;
`else
   localparam logic [4:0] MulLast = 5'd31;
`endif
   localparam logic [4:0] DivLast = 5'd31;

   state_e      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [63:0] acc_q, acc_d;
   logic [63:0] mcand_q, mcand_d;
   logic [32:0] mpl_q, mpl_d;
   logic [33:0] rem_q, rem_d;
   logic [31:0] quo_q, quo_d;
   logic [31:0] dvs_q, dvs_d;
   logic        neg_q, neg_d;
   logic [31:0] result_q, result_d;
   logic        exc_q, exc_d;

   logic [63:0] pp;
   logic [63:0] acc_sum;
   logic [33:0] rem_shift;
   logic [33:0] rem_next;
   logic [31:0] quo_next;
   logic [31:0] quo_fix;
   logic [31:0] a_mag;
   logic [31:0] b_mag;

   // Partial product for the current iteration.
   always_comb begin
      pp = '0;
`ifdef MULTDIV_RADIX4_EN
      case (mpl_q[2:0])
         3'b001, 3'b010: pp = mcand_q;
         3'b011:         pp = mcand_q << 1;
         3'b100:         pp = -(mcand_q << 1);
         3'b101, 3'b110: pp = -mcand_q;
         default:        pp = '0;
      endcase
`else
      // Bit 31 of a two's complement multiplier carries weight -2^31.
      if (mpl_q[0]) begin
         pp = (cnt_q == MulLast) ? -mcand_q : mcand_q;
      end
`endif
   end

   always_comb begin
      acc_sum   = acc_q + pp;
      rem_shift = {rem_q[32:0], quo_q[31]};
      rem_next  = rem_q[33] ? (rem_shift + {2'b00, dvs_q}) : (rem_shift - {2'b00, dvs_q});
      quo_next  = {quo_q[30:0], ~rem_next[33]};
      quo_fix   = neg_q ? -quo_next : quo_next;
      a_mag     = data_operandA[31] ? -data_operandA : data_operandA;
      b_mag     = data_operandB[31] ? -data_operandB : data_operandB;
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mpl_d    = mpl_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      dvs_d    = dvs_q;
      neg_d    = neg_q;
      result_d = result_q;
      exc_d    = exc_q;

      unique case (state_q)
         StIdle, StDone: begin
            state_d = StIdle;
            if (ctrl_MULT) begin
               state_d = StMulRun;
               cnt_d   = '0;
               acc_d   = '0;
               mcand_d = {{32{data_operandA[31]}}, data_operandA};
`ifdef MULTDIV_RADIX4_EN
               mpl_d   = {data_operandB, 1'b0};
`else
               mpl_d   = {data_operandB[31], data_operandB};
`endif
            end else if (ctrl_DIV) begin
               state_d = StDivRun;
               cnt_d   = '0;
               rem_d   = '0;
               quo_d   = a_mag;
               dvs_d   = b_mag;
               neg_d   = data_operandA[31] ^ data_operandB[31];
            end
         end
         StMulRun: begin
            acc_d = acc_sum;
            cnt_d = cnt_q + 5'd1;
`ifdef MULTDIV_RADIX4_EN
            mcand_d = mcand_q << 2;
            mpl_d   = mpl_q >> 2;
`else
            mcand_d = mcand_q << 1;
            mpl_d   = mpl_q >> 1;
`endif
            if (cnt_q == MulLast) begin
               state_d  = StDone;
               result_d = acc_sum[31:0];
               exc_d    = ~((&acc_sum[63:31]) | ~(|acc_sum[63:31]));
            end
         end
         StDivRun: begin
            if (dvs_q == '0) begin
               state_d  = StDone;
               result_d = '0;
               exc_d    = 1'b1;
            end else begin
               rem_d = rem_next;
               quo_d = quo_next;
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == DivLast) begin
                  state_d  = StDone;
                  result_d = quo_fix;
                  // A positive quotient of 2^31 only arises from MIN / -1.
                  exc_d    = ~neg_q & quo_next[31];
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mpl_q    <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         dvs_q    <= '0;
         neg_q    <= 1'b0;
         result_q <= '0;
         exc_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mpl_q    <= mpl_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         dvs_q    <= dvs_d;
         neg_q    <= neg_d;
         result_q <= result_d;
         exc_q    <= exc_d;
      end
   end

   assign data_result    = result_q;
   assign data_exception = exc_q;
   assign data_resultRDY = (state_q == StDone);

endmodule

// File: tb/tb_multdiv_unit.sv
// Scoreboard bench for multdiv_unit: directed vectors queued on issue, checked on each RDY.
`timescale 1ns/1ps
module tb_multdiv_unit;

`ifdef MULTDIV_RADIX4_EN
   localparam int MUL_LAT = 16;
`else
   localparam int MUL_LAT = 32;
`endif
   localparam int DIV_LAT = 32;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] data_operandA = '0;
   logic [31:0] data_operandB = '0;
   logic        ctrl_MULT = 1'b0;
   logic        ctrl_DIV = 1'b0;
   logic [31:0] data_result;
   logic        data_exception;
   logic        data_resultRDY;

   multdiv_unit #(.WIDTH(32)) dut (
      .clock          (clock),
      .reset          (reset),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .ctrl_MULT      (ctrl_MULT),
      .ctrl_DIV       (ctrl_DIV),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] res;
      logic        exc;
      int          cyc;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", name, got, want);
      end
   endtask

   // Monitor: every RDY strobe must match the oldest outstanding expectation.
   always @(negedge clock) begin
      if (!reset && data_resultRDY) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_rdy: got rdy=1 at cycle %0d want no strobe", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check({e.name, "_result"}, data_result, e.res);
            check({e.name, "_exc"}, {31'b0, data_exception}, {31'b0, e.exc});
            check({e.name, "_latency"}, cyc, e.cyc);
         end
      end
   end

   // Caller is positioned at a negedge; drives the pulse across exactly one edge (E0).
   task automatic start_op(input logic m, input logic d, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] res, input logic exc,
                           input int lat, input string name);
      exp_t e;
      data_operandA = a;
      data_operandB = b;
      ctrl_MULT     = m;
      ctrl_DIV      = d;
      @(posedge clock);
      #1;
      e.res  = res;
      e.exc  = exc;
      e.cyc  = cyc + lat;
      e.name = name;
      sb.push_back(e);
      ctrl_MULT     = 1'b0;
      ctrl_DIV      = 1'b0;
      data_operandA = 32'hDEADBEEF;
      data_operandB = 32'h0BADF00D;
   endtask

   task automatic wait_empty();
      for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clock);
      if (sb.size() != 0) begin
         total++;
         bad++;
         $display("FAIL timeout: got %0d pending results want 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic run_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic exc, input int lat,
                         input string name);
      @(negedge clock);
      start_op(m, d, a, b, res, exc, lat, name);
      wait_empty();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (3) @(negedge clock);
      check("reset_result", data_result, 32'h0);
      check("reset_exc", {31'b0, data_exception}, 32'h0);
      check("reset_rdy", {31'b0, data_resultRDY}, 32'h0);
      reset = 1'b0;

      run_op(1, 0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 0, MUL_LAT, "mul_7_m3");
      run_op(1, 0, 32'h00010000, 32'h00010000, 32'h0, 1, MUL_LAT, "mul_ovf");
      run_op(1, 0, 32'h80000000, 32'd1, 32'h80000000, 0, MUL_LAT, "mul_min_1");
      run_op(1, 0, 32'h7FFFFFFF, 32'd2, 32'hFFFFFFFE, 1, MUL_LAT, "mul_max_2");
      run_op(0, 1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 0, DIV_LAT, "div_m7_2");
      run_op(0, 1, 32'd100, 32'hFFFFFFF6, 32'hFFFFFFF6, 0, DIV_LAT, "div_100_m10");
      run_op(0, 1, 32'd5, 32'd0, 32'h0, 1, 1, "div_by_zero");
      run_op(0, 1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, DIV_LAT, "div_min_m1");
      run_op(0, 1, 32'h80000000, 32'd2, 32'hC0000000, 0, DIV_LAT, "div_min_2");
      run_op(0, 1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'd1, 0, DIV_LAT, "div_max_max");
      run_op(1, 1, 32'd6, 32'd3, 32'd18, 0, MUL_LAT, "mul_and_div");

      // Start sampled in the DONE cycle of a previous divide.
      @(negedge clock);
      start_op(0, 1, 32'd100, 32'd7, 32'd14, 0, DIV_LAT, "b2b_first");
      for (int i = 0; i < 100 && !data_resultRDY; i++) @(negedge clock);
      start_op(0, 1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 0, DIV_LAT, "b2b_second");
      wait_empty();

      // DIV pulse while a multiply is running must be ignored.
      @(negedge clock);
      start_op(1, 0, 32'hFFFFFFFB, 32'hFFFFFFFA, 32'd30, 0, MUL_LAT, "mul_div_ignored");
      repeat (5) @(negedge clock);
      data_operandA = 32'd100;
      data_operandB = 32'd7;
      ctrl_DIV      = 1'b1;
      @(negedge clock);
      ctrl_DIV = 1'b0;
      wait_empty();
      repeat (40) @(negedge clock);

      // Reset at E10 of a multiply, with a start pulse coincident with reset.
      @(negedge clock);
      data_operandA = 32'd9;
      data_operandB = 32'd9;
      ctrl_MULT     = 1'b1;
      @(posedge clock);
      #1;
      ctrl_MULT = 1'b0;
      repeat (9) @(posedge clock);
      @(negedge clock);
      reset     = 1'b1;
      ctrl_MULT = 1'b1;
      @(negedge clock);
      check("midreset_rdy", {31'b0, data_resultRDY}, 32'h0);
      check("midreset_result", data_result, 32'h0);
      check("midreset_exc", {31'b0, data_exception}, 32'h0);
      reset     = 1'b0;
      ctrl_MULT = 1'b0;
      repeat (40) @(negedge clock);
      check("after_reset_result", data_result, 32'h0);

      run_op(1, 0, 32'd3, 32'd4, 32'd12, 0, MUL_LAT, "mul_3_4");

      repeat (3) @(negedge clock);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
